// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
//
// Parametrised decode-stage register file with two write ports, two
// registered read ports and a per-register busy scoreboard for outstanding
// loads.
//
// Write port A carries ALU writeback. Write port B carries load writeback
// and also retires the busy flag of the register it writes. A load issue
// (mark_en) sets the busy flag of its destination register so the hazard
// unit can stall consumers until the load data comes back.
//
// Parameters:
//   DATA_W   - register and data width in bits
//   ADDR_W   - register address width, depth is 2**ADDR_W
//   ZERO_REG - 1: register 0 reads as zero, ignores writes, never busy
//   BYPASS   - 1: reads see same-edge write data (write-first)
//              0: reads see the contents from before the edge
//
// Ports:
//   clk        - clock, rising edge only
//   reset      - synchronous active-high reset, clears all state
//   ra1, ra2   - read addresses
//   rd1, rd2   - registered read data (1 cycle latency)
//   rd1_busy   - registered busy flag for ra1
//   rd2_busy   - registered busy flag for ra2
//   wea/waa/wda - write port A enable, address, data
//   web/wab/wdb - write port B enable, address, data (clears busy)
//   mark_en    - set busy on mark_addr (load issued)
//   mark_addr  - register to mark busy
// ----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              wea,
    input  logic [ADDR_W-1:0] waa,
    input  logic [DATA_W-1:0] wda,
    input  logic              web,
    input  logic [ADDR_W-1:0] wab,
    input  logic [DATA_W-1:0] wdb,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [DEPTH-1:0]  ONE_HOT0  = DEPTH'(1);

    // Register storage and scoreboard state
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Qualified write/mark strobes (register 0 filtered out when hardwired)
    logic              wr_a_ok;
    logic              wr_b_ok;
    logic              mark_ok;

    // Scoreboard decode and next state
    logic [DEPTH-1:0]  set_vec;
    logic [DEPTH-1:0]  clr_vec;
    logic [DEPTH-1:0]  busy_n;

    // Next values of the registered read outputs
    logic [DATA_W-1:0] rd1_n;
    logic [DATA_W-1:0] rd2_n;
    logic              rd1_busy_n;
    logic              rd2_busy_n;

    // Value an address presents to a read port on this edge. Port B is
    // checked first so that a same-address A/B collision shows B's data,
    // matching what ends up in the array.
    function automatic logic [DATA_W-1:0] read_word(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              a_ok,
        input logic [ADDR_W-1:0] a_addr,
        input logic [DATA_W-1:0] a_data,
        input logic              b_ok,
        input logic [ADDR_W-1:0] b_addr,
        input logic [DATA_W-1:0] b_data
    );
        logic [DATA_W-1:0] value;
        value = stored;
        if (BYPASS != 0) begin
            if (b_ok && (b_addr == addr)) begin
                value = b_data;
            end else if (a_ok && (a_addr == addr)) begin
                value = a_data;
            end
        end
        if ((ZERO_REG != 0) && (addr == ZERO_ADDR)) begin
            value = '0;
        end
        return value;
    endfunction

    // With a hardwired zero register, any write or mark aimed at address 0
    // is dropped here so nothing downstream has to special-case it.
    always_comb begin
        wr_a_ok = wea;
        wr_b_ok = web;
        mark_ok = mark_en;
        if (ZERO_REG != 0) begin
            if (waa == ZERO_ADDR) begin
                wr_a_ok = 1'b0;
            end
            if (wab == ZERO_ADDR) begin
                wr_b_ok = 1'b0;
            end
            if (mark_addr == ZERO_ADDR) begin
                mark_ok = 1'b0;
            end
        end
    end

    // Scoreboard next state: load writeback clears, load issue sets, and
    // set is applied after clear so a new load to the same register wins.
    // Port A writes deliberately leave busy alone.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (wr_b_ok) begin
            clr_vec = ONE_HOT0 << wab;
        end
        if (mark_ok) begin
            set_vec = ONE_HOT0 << mark_addr;
        end
        busy_n = (busy & ~clr_vec) | set_vec;
    end

    // Read-port next values. Busy is taken from the next-state vector so a
    // read on the retiring edge already sees the register as free.
    always_comb begin
        rd1_n      = read_word(ra1, rf[ra1], wr_a_ok, waa, wda, wr_b_ok, wab, wdb);
        rd2_n      = read_word(ra2, rf[ra2], wr_a_ok, waa, wda, wr_b_ok, wab, wdb);
        rd1_busy_n = busy_n[ra1];
        rd2_busy_n = busy_n[ra2];
        if ((ZERO_REG != 0) && (ra1 == ZERO_ADDR)) begin
            rd1_busy_n = 1'b0;
        end
        if ((ZERO_REG != 0) && (ra2 == ZERO_ADDR)) begin
            rd2_busy_n = 1'b0;
        end
    end

    // All state, including the read outputs, updates here. Reset dominates
    // and discards any write, mark or read presented on the same edge.
    // Port B's assignment comes second so it wins an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
            busy     <= '0;
            rd1      <= '0;
            rd2      <= '0;
            rd1_busy <= 1'b0;
            rd2_busy <= 1'b0;
        end else begin
            if (wr_a_ok) begin
                rf[waa] <= wda;
            end
            if (wr_b_ok) begin
                rf[wab] <= wdb;
            end
            busy     <= busy_n;
            rd1      <= rd1_n;
            rd2      <= rd2_n;
            rd1_busy <= rd1_busy_n;
            rd2_busy <= rd2_busy_n;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
//
// Bench for regfile_sb. Two 16x8 instances share one directed stimulus
// stream: dut_a hardwires register 0 and bypasses, dut_b does neither.
// Four 32x32 instances, one per ZERO_REG/BYPASS combination, share a
// random stimulus stream and are compared against a behavioural model.
// ----------------------------------------------------------------------------
module tb_regfile_sb;

    logic clk;
    int   checks;
    int   failures;

    // Clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Directed-stream inputs (16-bit data, 3-bit addresses)
    logic        reset;
    logic [2:0]  ra1, ra2, waa, wab, mark_addr;
    logic [15:0] wda, wdb;
    logic        wea, web, mark_en;

    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_b1, a_b2, b_b1, b_b2;

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
        .rd1(a_rd1), .rd2(a_rd2), .rd1_busy(a_b1), .rd2_busy(a_b2),
        .wea(wea), .waa(waa), .wda(wda), .web(web), .wab(wab), .wdb(wdb),
        .mark_en(mark_en), .mark_addr(mark_addr)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
        .rd1(b_rd1), .rd2(b_rd2), .rd1_busy(b_b1), .rd2_busy(b_b2),
        .wea(wea), .waa(waa), .wda(wda), .web(web), .wab(wab), .wdb(wdb),
        .mark_en(mark_en), .mark_addr(mark_addr)
    );

    // Random-stream inputs (32-bit data, 5-bit addresses)
    logic        r_reset;
    logic [4:0]  r_ra1, r_ra2, r_waa, r_wab, r_mark_addr;
    logic [31:0] r_wda, r_wdb;
    logic        r_wea, r_web, r_mark_en;

    logic [31:0] r_rd1 [4];
    logic [31:0] r_rd2 [4];
    logic        r_b1  [4];
    logic        r_b2  [4];

    // Instance g: ZERO_REG = g/2, BYPASS = g%2
    for (genvar g = 0; g < 4; g++) begin : g_rand
        regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(g / 2), .BYPASS(g % 2)) dut (
            .clk(clk), .reset(r_reset), .ra1(r_ra1), .ra2(r_ra2),
            .rd1(r_rd1[g]), .rd2(r_rd2[g]), .rd1_busy(r_b1[g]), .rd2_busy(r_b2[g]),
            .wea(r_wea), .waa(r_waa), .wda(r_wda), .web(r_web), .wab(r_wab), .wdb(r_wdb),
            .mark_en(r_mark_en), .mark_addr(r_mark_addr)
        );
    end

    // Directed vector: inputs for one edge plus expected outputs after it
    typedef struct {
        logic        reset;
        logic        wea;
        logic [2:0]  waa;
        logic [15:0] wda;
        logic        web;
        logic [2:0]  wab;
        logic [15:0] wdb;
        logic        mark_en;
        logic [2:0]  mark_addr;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [15:0] a_rd1;
        logic        a_b1;
        logic [15:0] a_rd2;
        logic        a_b2;
        logic [15:0] b_rd1;
        logic        b_b1;
        logic [15:0] b_rd2;
        logic        b_b2;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(
        input logic rst, input logic we_a, input logic [2:0] wa_a, input logic [15:0] wd_a,
        input logic we_b, input logic [2:0] wa_b, input logic [15:0] wd_b,
        input logic mk, input logic [2:0] mk_a, input logic [2:0] r1, input logic [2:0] r2,
        input logic [15:0] ea1, input logic eab1, input logic [15:0] ea2, input logic eab2,
        input logic [15:0] eb1, input logic ebb1, input logic [15:0] eb2, input logic ebb2
    );
        vec_t v;
        v.reset = rst; v.wea = we_a; v.waa = wa_a; v.wda = wd_a;
        v.web = we_b; v.wab = wa_b; v.wdb = wd_b;
        v.mark_en = mk; v.mark_addr = mk_a; v.ra1 = r1; v.ra2 = r2;
        v.a_rd1 = ea1; v.a_b1 = eab1; v.a_rd2 = ea2; v.a_b2 = eab2;
        v.b_rd1 = eb1; v.b_b1 = ebb1; v.b_rd2 = eb2; v.b_b2 = ebb2;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setIdle(input logic [2:0] r1, input logic [2:0] r2);
        reset = 1'b0; wea = 1'b0; waa = '0; wda = '0;
        web = 1'b0; wab = '0; wdb = '0;
        mark_en = 1'b0; mark_addr = '0;
        ra1 = r1; ra2 = r2;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset = v.reset; wea = v.wea; waa = v.waa; wda = v.wda;
        web = v.web; wab = v.wab; wdb = v.wdb;
        mark_en = v.mark_en; mark_addr = v.mark_addr;
        ra1 = v.ra1; ra2 = v.ra2;
        tick();
    endtask

    task automatic checkOutput(
        input string name,
        input logic [31:0] act1, input logic actb1, input logic [31:0] act2, input logic actb2,
        input logic [31:0] exp1, input logic expb1, input logic [31:0] exp2, input logic expb2
    );
        checks++;
        if (act1 !== exp1 || actb1 !== expb1 || act2 !== exp2 || actb2 !== expb2) begin
            failures++;
            $display("[TB] FAIL %s: got rd1=%h b1=%b rd2=%h b2=%b, expected rd1=%h b1=%b rd2=%h b2=%b",
                     name, act1, actb1, act2, actb2, exp1, expb1, exp2, expb2);
        end
    endtask

    // Behavioural model of the four random instances
    logic [31:0] m_rf [4][32];
    logic [31:0] m_busy [4];
    logic [31:0] e_rd1 [4];
    logic [31:0] e_rd2 [4];
    logic        e_b1  [4];
    logic        e_b2  [4];

    function automatic logic [31:0] modelRead(input int k, input logic [4:0] addr,
                                              input logic wa_ok, input logic wb_ok);
        logic [31:0] val;
        val = m_rf[k][addr];
        if ((k % 2) == 1) begin
            if (wb_ok && r_wab == addr) val = r_wdb;
            else if (wa_ok && r_waa == addr) val = r_wda;
        end
        if ((k / 2) == 1 && addr == 5'd0) val = 32'd0;
        return val;
    endfunction

    // Predict the outputs after the coming edge, then advance the model
    task automatic modelStep(input int k);
        logic        zr;
        logic        wa_ok, wb_ok, mk_ok;
        logic [31:0] nb;
        zr = ((k / 2) == 1);
        if (r_reset) begin
            e_rd1[k] = '0; e_rd2[k] = '0; e_b1[k] = 1'b0; e_b2[k] = 1'b0;
            for (int i = 0; i < 32; i++) m_rf[k][i] = '0;
            m_busy[k] = '0;
            return;
        end
        wa_ok = r_wea && !(zr && r_waa == 5'd0);
        wb_ok = r_web && !(zr && r_wab == 5'd0);
        mk_ok = r_mark_en && !(zr && r_mark_addr == 5'd0);
        nb = m_busy[k];
        if (wb_ok) nb[r_wab] = 1'b0;
        if (mk_ok) nb[r_mark_addr] = 1'b1;
        e_rd1[k] = modelRead(k, r_ra1, wa_ok, wb_ok);
        e_rd2[k] = modelRead(k, r_ra2, wa_ok, wb_ok);
        e_b1[k]  = (zr && r_ra1 == 5'd0) ? 1'b0 : nb[r_ra1];
        e_b2[k]  = (zr && r_ra2 == 5'd0) ? 1'b0 : nb[r_ra2];
        if (wa_ok) m_rf[k][r_waa] = r_wda;
        if (wb_ok) m_rf[k][r_wab] = r_wdb;
        m_busy[k] = nb;
    endtask

    function automatic logic [4:0] randAddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        setIdle(3'd0, 3'd0);
        reset = 1'b1;
        r_reset = 1'b1; r_ra1 = '0; r_ra2 = '0; r_wea = 1'b0; r_waa = '0; r_wda = '0;
        r_web = 1'b0; r_wab = '0; r_wdb = '0; r_mark_en = 1'b0; r_mark_addr = '0;

        //     rst wea waa wda        web wab wdb        mk ma ra1 ra2  A:rd1 b1 rd2 b2            B:rd1 b1 rd2 b2
        addVec(1, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 3, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        addVec(1, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 3, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 3, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        addVec(0, 1, 5, 16'hAAAA, 1, 5, 16'h5555, 0, 0, 5, 5, 16'h5555, 0, 16'h5555, 0, 16'h0000, 0, 16'h0000, 0);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 5, 16'h5555, 0, 16'h5555, 0, 16'h5555, 0, 16'h5555, 0);
        addVec(0, 1, 2, 16'h00FF, 0, 0, 16'h0000, 0, 0, 2, 2, 16'h00FF, 0, 16'h00FF, 0, 16'h0000, 0, 16'h0000, 0);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 2, 16'h00FF, 0, 16'h00FF, 0, 16'h00FF, 0, 16'h00FF, 0);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4, 4, 4, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1);
        addVec(0, 1, 4, 16'h1111, 0, 0, 16'h0000, 0, 0, 4, 4, 16'h1111, 1, 16'h1111, 1, 16'h0000, 1, 16'h0000, 1);
        addVec(0, 0, 0, 16'h0000, 1, 4, 16'hBEEF, 0, 0, 4, 4, 16'hBEEF, 0, 16'hBEEF, 0, 16'h1111, 0, 16'h1111, 0);
        addVec(0, 0, 0, 16'h0000, 1, 4, 16'hCAFE, 1, 4, 4, 4, 16'hCAFE, 1, 16'hCAFE, 1, 16'hBEEF, 1, 16'hBEEF, 1);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 4, 16'hCAFE, 1, 16'hCAFE, 1, 16'hCAFE, 1, 16'hCAFE, 1);
        addVec(0, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 1, 16'hFFFF, 1);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 4, 16'h0000, 0, 16'hCAFE, 1, 16'hFFFF, 1, 16'hCAFE, 1);
        addVec(0, 1, 6, 16'h6666, 1, 0, 16'h0BAD, 0, 0, 6, 0, 16'h6666, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 0);
        addVec(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 6, 0, 16'h6666, 0, 16'h0000, 0, 16'h6666, 0, 16'h0BAD, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_a", i), 32'(a_rd1), a_b1, 32'(a_rd2), a_b2,
                        32'(vecs[i].a_rd1), vecs[i].a_b1, 32'(vecs[i].a_rd2), vecs[i].a_b2);
            checkOutput($sformatf("vec%0d_b", i), 32'(b_rd1), b_b1, 32'(b_rd2), b_b2,
                        32'(vecs[i].b_rd1), vecs[i].b_b1, 32'(vecs[i].b_rd2), vecs[i].b_b2);
        end

        // Mark r1..r7 busy one per cycle, each visible on the next read
        for (int a = 1; a < 8; a++) begin
            setIdle(3'(a), 3'(a));
            mark_en = 1'b1;
            mark_addr = 3'(a);
            tick();
            checkOutput($sformatf("mark_r%0d_a", a), 32'd0, a_b1, 32'd0, a_b2, 32'd0, 1'b1, 32'd0, 1'b1);
            checkOutput($sformatf("mark_r%0d_b", a), 32'd0, b_b1, 32'd0, b_b2, 32'd0, 1'b1, 32'd0, 1'b1);
        end

        // One reset cycle aborts every pending load; the mark is discarded
        setIdle(3'd2, 3'd5);
        reset = 1'b1;
        mark_en = 1'b1;
        mark_addr = 3'd2;
        tick();
        checkOutput("midreset_a", 32'(a_rd1), a_b1, 32'(a_rd2), a_b2, 32'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("midreset_b", 32'(b_rd1), b_b1, 32'(b_rd2), b_b2, 32'd0, 1'b0, 32'd0, 1'b0);

        // Load writeback to r3 after the reset
        setIdle(3'd3, 3'd1);
        web = 1'b1;
        wab = 3'd3;
        wdb = 16'h3333;
        tick();
        checkOutput("postreset_wb_a", 32'(a_rd1), a_b1, 32'(a_rd2), a_b2, 32'h3333, 1'b0, 32'd0, 1'b0);
        checkOutput("postreset_wb_b", 32'(b_rd1), b_b1, 32'(b_rd2), b_b2, 32'd0, 1'b0, 32'd0, 1'b0);

        // Sweep every register: nothing busy, only r3 holds data
        for (int a = 0; a < 8; a++) begin
            setIdle(3'(a), 3'(7 - a));
            tick();
            checkOutput($sformatf("sweep_r%0d_a", a), 32'(a_rd1), a_b1, 32'(a_rd2), a_b2,
                        (a == 3) ? 32'h3333 : 32'd0, 1'b0, (7 - a == 3) ? 32'h3333 : 32'd0, 1'b0);
            checkOutput($sformatf("sweep_r%0d_b", a), 32'(b_rd1), b_b1, 32'(b_rd2), b_b2,
                        (a == 3) ? 32'h3333 : 32'd0, 1'b0, (7 - a == 3) ? 32'h3333 : 32'd0, 1'b0);
        end

        // Random traffic on the wide instances against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            r_reset     = (cyc == 0) || ($urandom_range(0, 63) == 0);
            r_wea       = ($urandom_range(0, 1) == 1);
            r_waa       = randAddr();
            r_wda       = $urandom();
            r_web       = ($urandom_range(0, 2) == 0);
            r_wab       = randAddr();
            r_wdb       = $urandom();
            r_mark_en   = ($urandom_range(0, 2) == 0);
            r_mark_addr = randAddr();
            r_ra1       = randAddr();
            r_ra2       = randAddr();
            for (int k = 0; k < 4; k++) modelStep(k);
            tick();
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("rand_c%0d_z%0d_b%0d", cyc, k / 2, k % 2),
                            r_rd1[k], r_b1[k], r_rd2[k], r_b2[k],
                            e_rd1[k], e_b1[k], e_rd2[k], e_b2[k]);
            end
        end

        $display("[TB] directed and random phases complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write register file, generalised in data width and register count. It has two write ports: write port A for ALU writeback and write port B for load writeback. Two read ports are registered on the rising edge with write-first bypass, and a per-register busy scoreboard tracks outstanding loads so the hazard unit can stall. It sits in the decode stage of the pipeline. It uses a single clock and a synchronous reset that clears all state.

Parameters:
DATA_W, 16, register and data width in bits
ADDR_W, 3, register address width; depth is 2**ADDR_W
ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy
BYPASS, 1, when 1, reads return same-cycle write data (write-first); when 0, they return pre-write contents

Ports:
clk  in  1  clock, rising edge only
reset  in  1  synchronous, active-high; clears all state
ra1  in  ADDR_W  read address, port 1
ra2  in  ADDR_W  read address, port 2
rd1  out  DATA_W  registered read data, port 1
rd2  out  DATA_W  registered read data, port 2
rd1_busy  out  1  registered busy flag for ra1
rd2_busy  out  1  registered busy flag for ra2
wea  in  1  write enable, port A (ALU)
waa  in  ADDR_W  write address, port A
wda  in  DATA_W  write data, port A
web  in  1  write enable, port B (load writeback); clears busy
wab  in  ADDR_W  write address, port B
wdb  in  DATA_W  write data, port B
mark_en  in  1  set busy on mark_addr (load issued)
mark_addr  in  ADDR_W  register to mark busy

Behaviour:
- Storage: 2**ADDR_W x DATA_W flops. The busy vector is 2**ADDR_W bits.
- Reset (synchronous, dominant over everything):
  - all registers go to 0 and all busy bits go to 0.
  - rd1, rd2, rd1_busy and rd2_busy go to 0 on the reset edge.
  - writes, marks and reads presented during reset are discarded.
  - Reset asserted mid-sequence aborts every pending busy state.
- Writes at the rising edge:
  - port A writes rf[waa] when wea is 1.
  - port B writes rf[wab] when web is 1.
  - If waa equals wab with both enables set, port B wins and port A's data is lost.
- Busy next-state per register i: busy_n[i] = (busy[i] and not clr[i]) or set[i].
  - clr[i] = web and wab equals i.
  - set[i] = mark_en and mark_addr equals i.
  - A simultaneous set and clear on the same register leaves the register busy (the new load wins).
  - A port A write does not clear busy.
- Reads: latency is 1 cycle. At each rising edge rd1 is loaded with the data value of ra1 and rd1_busy with busy_n[ra1]. Port 2 behaves the same for ra2.
- Data value of an address when BYPASS is 1: wdb if web is set and wab matches; else wda if wea is set and waa matches; else rf[addr].
- Data value of an address when BYPASS is 0: rf[addr], the pre-edge contents.
- Outputs hold their values between edges. Read ports are independent, and both may address the same register.
- ZERO_REG = 1:
  - writes to address 0 on either port are ignored and mark_en on address 0 is ignored.
  - reads of address 0 return 0 with busy 0, regardless of bypass.
  - a port B write to 0 does not override a port A write elsewhere.
- ZERO_REG = 0: register 0 is an ordinary register.
- No X propagation: every output is defined from the first post-reset edge.
- Address widths are exact, so no out-of-range addresses are possible.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then read: assert reset for 2 cycles with wea=1, waa=3, wda=16'h1234. Then read ra1=3 -> rd1=16'h0000 and rd1_busy=0. All outputs are 0 during reset.
- Bypass and conflict (BYPASS=1): on one edge set wea=1, waa=5, wda=16'hAAAA and web=1, wab=5, wdb=16'h5555, with ra1=5. The next cycle shows rd1=16'h5555. One cycle later, with no writes, rd1 still reads 16'h5555.
- Non-bypass (BYPASS=0): write 16'h00FF to r2 while ra2=2 on the same edge -> rd2 shows the old value 16'h0000. The following edge shows 16'h00FF.
- Scoreboard:
  - mark_en with mark_addr=4 -> rd1_busy=1 for ra1=4 on the next edge.
  - wea to r4 -> rd1_busy stays 1.
  - web with wab=4, wdb=16'hBEEF -> rd1=16'hBEEF and rd1_busy=0 on the same read edge.
  - Simultaneous mark_en and web on r4 -> busy stays 1.
- Zero register (ZERO_REG=1):
  - wea with waa=0, wda=16'hFFFF -> ra1=0 reads 0.
  - mark_en with mark_addr=0 -> rd1_busy stays 0.
  - Repeat with ZERO_REG=0 -> r0 reads 16'hFFFF and its busy sets normally.
- Reset mid-load: mark r1..r7 busy, assert reset for 1 cycle, then web to r3 -> all busy flags read 0 afterwards and r3 holds wdb. Also run a randomized check of 2000 cycles against a reference model, covering all parameter combinations with DATA_W=32 and ADDR_W=5.
